// File: rtl/cpu_v7.sv
// rtl/cpu_v7.sv - single-cycle accumulator-style CPU with synced input ports and ready handshake
module cpu_v7 #(
  parameter int BUS_WIDTH        = 8,
  parameter int REG_ADDR_WIDTH   = 2,
  parameter int INSTR_ADDR_WIDTH = 4,
  parameter int NUM_IN_PORTS     = 2
) (
  input  logic                                       clk,
  input  logic                                       n_reset,
  output logic [INSTR_ADDR_WIDTH-1:0]                instr_addr,
  input  logic [4+2*REG_ADDR_WIDTH+BUS_WIDTH-1:0]    instr,
  input  logic [NUM_IN_PORTS*BUS_WIDTH-1:0]          in_port,
  input  logic                                       ready_in,
  output logic [BUS_WIDTH-1:0]                       out_port,
  output logic                                       out_valid
);

  localparam int INSTR_WIDTH = 4 + 2*REG_ADDR_WIDTH + BUS_WIDTH;
  localparam int NUM_REGS    = 2**REG_ADDR_WIDTH;

  localparam logic [3:0] OP_LDI   = 4'd1;
  localparam logic [3:0] OP_MOV   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_ADDI  = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_IN    = 4'd6;
  localparam logic [3:0] OP_OUT   = 4'd7;
  localparam logic [3:0] OP_JMP   = 4'd8;
  localparam logic [3:0] OP_JZ    = 4'd9;
  localparam logic [3:0] OP_JC    = 4'd10;
  localparam logic [3:0] OP_WAITL = 4'd11;
  localparam logic [3:0] OP_WAITE = 4'd12;

  // Architectural state
  logic [INSTR_ADDR_WIDTH-1:0]       r_pc;
  logic [BUS_WIDTH-1:0]              r_regs [NUM_REGS];
  logic                              r_z;
  logic                              r_c;
  logic [BUS_WIDTH-1:0]              r_out_port;
  logic                              r_out_valid;

  // Synchronizer and edge-detect state
  logic [NUM_IN_PORTS*BUS_WIDTH-1:0] r_in_s1;
  logic [NUM_IN_PORTS*BUS_WIDTH-1:0] r_in_s2;
  logic                              r_rdy_s1;
  logic                              r_rdy_s2;
  logic                              r_rdy_prev;

  // Decoded fields and datapath values
  logic [3:0]                        w_op;
  logic [REG_ADDR_WIDTH-1:0]         w_rd;
  logic [REG_ADDR_WIDTH-1:0]         w_rs;
  logic [BUS_WIDTH-1:0]              w_imm;
  logic [INSTR_ADDR_WIDTH-1:0]       w_target;
  logic [BUS_WIDTH-1:0]              w_rd_val;
  logic [BUS_WIDTH-1:0]              w_rs_val;
  logic [BUS_WIDTH:0]                w_sum;
  logic [BUS_WIDTH:0]                w_sumi;
  logic [BUS_WIDTH:0]                w_diff;
  logic [BUS_WIDTH-1:0]              w_in_val;
  logic                              w_rdy_edge;
  logic [INSTR_ADDR_WIDTH-1:0]       w_pc_inc;
  logic [INSTR_ADDR_WIDTH-1:0]       w_pc_next;

  assign w_op     = instr[INSTR_WIDTH-1 -: 4];
  assign w_rd     = instr[INSTR_WIDTH-5 -: REG_ADDR_WIDTH];
  assign w_rs     = instr[INSTR_WIDTH-5-REG_ADDR_WIDTH -: REG_ADDR_WIDTH];
  assign w_imm    = instr[BUS_WIDTH-1:0];
  assign w_target = w_imm[INSTR_ADDR_WIDTH-1:0];

  // Both operands are read before the edge, so rd==rs uses one consistent value
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];

  // Extra top bit carries the carry-out (add) or borrow (sub)
  assign w_sum  = {1'b0, w_rd_val} + {1'b0, w_rs_val};
  assign w_sumi = {1'b0, w_rd_val} + {1'b0, w_imm};
  assign w_diff = {1'b0, w_rd_val} - {1'b0, w_rs_val};

  assign w_rdy_edge = r_rdy_s2 & ~r_rdy_prev;
  assign w_pc_inc   = r_pc + INSTR_ADDR_WIDTH'(1);

  assign instr_addr = r_pc;
  assign out_port   = r_out_port;
  assign out_valid  = r_out_valid;

  // Select the synced input port named by imm; out-of-range ports read as zero
  always_comb begin
    w_in_val = '0;
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      if (w_imm == BUS_WIDTH'(k)) begin
        w_in_val = r_in_s2[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Next PC: jumps use pre-edge flags, waits hold the PC until their condition holds
  always_comb begin
    w_pc_next = w_pc_inc;
    case (w_op)
      OP_JMP:   w_pc_next = w_target;
      OP_JZ:    w_pc_next = r_z ? w_target : w_pc_inc;
      OP_JC:    w_pc_next = r_c ? w_target : w_pc_inc;
      OP_WAITL: w_pc_next = (r_rdy_s2 == w_imm[0]) ? w_pc_inc : r_pc;
      OP_WAITE: w_pc_next = w_rdy_edge ? w_pc_inc : r_pc;
      default:  w_pc_next = w_pc_inc;
    endcase
  end

  // Two-flop synchronizers; the edge-detect sample updates every cycle regardless of opcode
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_in_s1    <= '0;
      r_in_s2    <= '0;
      r_rdy_s1   <= 1'b0;
      r_rdy_s2   <= 1'b0;
      r_rdy_prev <= 1'b0;
    end else begin
      r_in_s1    <= in_port;
      r_in_s2    <= r_in_s1;
      r_rdy_s1   <= ready_in;
      r_rdy_s2   <= r_rdy_s1;
      r_rdy_prev <= r_rdy_s2;
    end
  end

  // Execute the presented instruction and commit its results at this edge
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pc        <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_out_port  <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_pc        <= w_pc_next;
      r_out_valid <= 1'b0;
      case (w_op)
        OP_LDI: r_regs[w_rd] <= w_imm;
        OP_MOV: r_regs[w_rd] <= w_rs_val;
        OP_ADD: begin
          r_regs[w_rd] <= w_sum[BUS_WIDTH-1:0];
          r_c          <= w_sum[BUS_WIDTH];
          r_z          <= (w_sum[BUS_WIDTH-1:0] == '0);
        end
        OP_ADDI: begin
          r_regs[w_rd] <= w_sumi[BUS_WIDTH-1:0];
          r_c          <= w_sumi[BUS_WIDTH];
          r_z          <= (w_sumi[BUS_WIDTH-1:0] == '0);
        end
        OP_SUB: begin
          r_regs[w_rd] <= w_diff[BUS_WIDTH-1:0];
          r_c          <= w_diff[BUS_WIDTH];
          r_z          <= (w_diff[BUS_WIDTH-1:0] == '0);
        end
        OP_IN: r_regs[w_rd] <= w_in_val;
        OP_OUT: begin
          r_out_port  <= w_rs_val;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_v7.sv
// tb/tb_cpu_v7.sv - directed vector bench for cpu_v7
module tb_cpu_v7;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [3:0]  instr_addr;
  logic [15:0] instr;
  logic [15:0] in_port;
  logic        ready_in;
  logic [7:0]  out_port;
  logic        out_valid;

  logic [15:0] rom [16];

  int n_chk = 0;
  int n_err = 0;

  cpu_v7 #(
    .BUS_WIDTH(8), .REG_ADDR_WIDTH(2), .INSTR_ADDR_WIDTH(4), .NUM_IN_PORTS(2)
  ) dut (
    .clk(clk), .n_reset(n_reset), .instr_addr(instr_addr), .instr(instr),
    .in_port(in_port), .ready_in(ready_in), .out_port(out_port), .out_valid(out_valid)
  );

  assign instr = rom[instr_addr];

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0][15:0] prog;
    logic [15:0]      inp;
    int               cycles;
    logic [7:0]       exp_out;
    logic [3:0]       exp_pc;
    logic             exp_valid;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic vec_t mkv(input logic [15:0] p0, p1, p2, p3, p4, p5,
                               input logic [15:0] inp, input int cycles,
                               input logic [7:0] eo, input logic [3:0] ep, input logic ev);
    vec_t v;
    v.prog      = {p5, p4, p3, p2, p1, p0};
    v.inp       = inp;
    v.cycles    = cycles;
    v.exp_out   = eo;
    v.exp_pc    = ep;
    v.exp_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 16; i++) rom[i] = (i < 6) ? v.prog[i] : 16'h0000;
  endtask

  localparam logic [15:0] NOP = 16'h0000;

  initial begin
    n_reset  = 1'b0;
    ready_in = 1'b0;
    in_port  = 16'h0000;
    for (int i = 0; i < 16; i++) rom[i] = NOP;

    vecs[0]  = mkv(enc(1,0,0,200), enc(4,0,0,100), enc(7,0,0,0), enc(10,0,0,12), NOP, NOP, 16'h0, 4, 8'd44, 4'd12, 1'b0);
    vecs[1]  = mkv(enc(1,0,0,200), enc(4,0,0,100), enc(9,0,0,9), NOP, NOP, NOP, 16'h0, 3, 8'd0, 4'd3, 1'b0);
    vecs[2]  = mkv(enc(1,1,0,5), enc(5,1,1,0), enc(9,0,0,10), NOP, NOP, NOP, 16'h0, 3, 8'd0, 4'd10, 1'b0);
    vecs[3]  = mkv(enc(1,1,0,5), NOP, enc(9,0,0,10), NOP, NOP, NOP, 16'h0, 3, 8'd0, 4'd3, 1'b0);
    vecs[4]  = mkv(enc(1,1,0,5), enc(5,1,1,0), enc(10,0,0,10), NOP, NOP, NOP, 16'h0, 3, 8'd0, 4'd3, 1'b0);
    vecs[5]  = mkv(enc(1,0,0,3), enc(1,1,0,5), enc(5,0,1,0), enc(7,0,0,0), enc(10,0,0,9), NOP, 16'h0, 5, 8'd254, 4'd9, 1'b0);
    vecs[6]  = mkv(enc(1,2,0,8'h81), enc(3,2,2,0), enc(7,0,2,0), enc(10,0,0,14), NOP, NOP, 16'h0, 4, 8'h02, 4'd14, 1'b0);
    vecs[7]  = mkv(enc(1,3,0,8'h10), enc(2,0,3,0), enc(3,0,3,0), enc(7,0,0,0), enc(10,0,0,9), NOP, 16'h0, 5, 8'h20, 4'd5, 1'b0);
    vecs[8]  = mkv(enc(1,1,0,8'hFF), enc(4,1,0,1), enc(9,0,0,7), NOP, NOP, NOP, 16'h0, 3, 8'd0, 4'd7, 1'b0);
    vecs[9]  = mkv(enc(8,0,0,11), NOP, NOP, NOP, NOP, NOP, 16'h0, 1, 8'd0, 4'd11, 1'b0);
    vecs[10] = mkv(enc(1,0,0,8'hFF), enc(4,0,0,1), enc(1,0,0,5), enc(9,0,0,8), NOP, NOP, 16'h0, 4, 8'd0, 4'd8, 1'b0);
    vecs[11] = mkv(NOP, NOP, enc(6,2,0,1), enc(6,3,0,7), enc(7,0,2,0), enc(7,0,3,0), 16'h5A11, 5, 8'h5A, 4'd5, 1'b1);
    vecs[12] = mkv(NOP, NOP, enc(6,2,0,1), enc(6,3,0,7), enc(7,0,2,0), enc(7,0,3,0), 16'h5A11, 6, 8'h00, 4'd6, 1'b1);
    vecs[13] = mkv(NOP, NOP, enc(6,1,0,0), enc(7,0,1,0), NOP, NOP, 16'h5A11, 4, 8'h11, 4'd4, 1'b1);
    vecs[14] = mkv(enc(11,0,0,0), NOP, NOP, NOP, NOP, NOP, 16'h0, 1, 8'd0, 4'd1, 1'b0);
    vecs[15] = mkv(enc(1,0,0,9), enc(1,1,0,4), enc(5,0,1,0), enc(7,0,0,0), enc(10,0,0,12), NOP, 16'h0, 5, 8'd5, 4'd5, 1'b0);

    @(negedge clk);
    chk("reset pc", 32'(instr_addr), 32'd0);
    chk("reset out_port", 32'(out_port), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);

    // Table-driven programs
    for (int v = 0; v < 16; v++) begin
      load(vecs[v]);
      in_port  = vecs[v].inp;
      ready_in = 1'b0;
      do_reset();
      for (int c = 0; c < vecs[v].cycles; c++) tick();
      chk($sformatf("vec%0d pc", v), 32'(instr_addr), 32'(vecs[v].exp_pc));
      chk($sformatf("vec%0d out_port", v), 32'(out_port), 32'(vecs[v].exp_out));
      chk($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
    end

    // out_valid is a single-cycle pulse and out_port holds afterwards
    load(vecs[0]);
    in_port = 16'h0;
    do_reset();
    tick(); tick();
    chk("pulse before", 32'(out_valid), 32'd0);
    tick();
    chk("pulse high", 32'(out_valid), 32'd1);
    chk("pulse value", 32'(out_port), 32'd44);
    tick();
    chk("pulse after", 32'(out_valid), 32'd0);
    chk("pulse hold", 32'(out_port), 32'd44);

    // Sixteen NOPs: PC counts through and wraps
    for (int i = 0; i < 16; i++) rom[i] = NOP;
    do_reset();
    chk("nop pc0", 32'(instr_addr), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("nop pc%0d", i), 32'(instr_addr), 32'(i % 16));
    end

    // WAITE: stalls while ready low, advances on the third edge after the rise
    rom[0] = enc(12,0,0,0);
    ready_in = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("waite stalled", 32'(instr_addr), 32'd0);
    ready_in = 1'b1;
    tick();
    chk("waite edge1", 32'(instr_addr), 32'd0);
    tick();
    chk("waite edge2", 32'(instr_addr), 32'd0);
    tick();
    chk("waite edge3", 32'(instr_addr), 32'd1);

    // WAITE fetched after ready already high: the earlier edge is not captured
    for (int i = 0; i < 16; i++) rom[i] = NOP;
    rom[3] = enc(12,0,0,0);
    ready_in = 1'b1;
    do_reset();
    repeat (20) tick();
    chk("waite prehigh", 32'(instr_addr), 32'd3);

    // WAITL stall holds out_port; asynchronous reset aborts it
    for (int i = 0; i < 16; i++) rom[i] = NOP;
    rom[0] = enc(1,0,0,8'h77);
    rom[1] = enc(7,0,0,0);
    rom[2] = enc(11,0,0,1);
    ready_in = 1'b0;
    do_reset();
    repeat (8) tick();
    chk("waitl stalled pc", 32'(instr_addr), 32'd2);
    chk("waitl hold out", 32'(out_port), 32'h77);
    chk("waitl valid low", 32'(out_valid), 32'd0);
    #2 n_reset = 1'b0;
    #1;
    chk("async rst pc", 32'(instr_addr), 32'd0);
    chk("async rst out", 32'(out_port), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;

    // WAITL releases once synced ready matches imm[0]
    do_reset();
    repeat (4) tick();
    chk("waitl pre", 32'(instr_addr), 32'd2);
    ready_in = 1'b1;
    tick(); tick();
    chk("waitl sync", 32'(instr_addr), 32'd2);
    tick();
    chk("waitl go", 32'(instr_addr), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
